// File: rtl/fetch_bp_bht.sv
// ============================================================================
// Module   : fetch_bp_bht
// Purpose  : 2-bit saturating-counter branch history table with a one-cycle
//            lookup and a valid/ready queue draining one resolved outcome/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_bp_bht #(
    parameter int INDEX_BITS = 6,
    parameter int UPDQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_pred_valid,
    input  logic [31:0]                   i_pred_pc,
    output logic                          o_pred_valid,
    output logic                          o_pred_taken,
    output logic [1:0]                    o_pred_counter,
    input  logic                          i_upd_valid,
    output logic                          o_upd_ready,
    input  logic [31:0]                   i_upd_pc,
    input  logic                          i_upd_taken,
    output logic [$clog2(UPDQ_DEPTH):0]   o_updq_count
);

    localparam int c_ENTRIES = 1 << INDEX_BITS;
    localparam int c_PTR_W   = $clog2(UPDQ_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(UPDQ_DEPTH);

    logic [1:0]            r_table [c_ENTRIES];
    logic [INDEX_BITS-1:0] r_q_idx [UPDQ_DEPTH];
    logic                  r_q_taken [UPDQ_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  r_pred_valid;
    logic                  r_pred_taken;
    logic [1:0]            r_pred_counter;

    logic                  w_enq;
    logic                  w_deq;
    logic [INDEX_BITS-1:0] w_head_idx;
    logic                  w_head_taken;
    logic [1:0]            w_head_cur;
    logic [1:0]            w_head_new;
    logic [INDEX_BITS-1:0] w_pred_idx;
    logic [1:0]            w_pred_cnt;

    // Ready looks only at the registered count, never at this cycle's drain.
    assign o_upd_ready  = (r_count != c_DEPTH);
    assign w_enq        = i_upd_valid & o_upd_ready;
    assign w_deq        = (r_count != '0);
    assign w_head_idx   = r_q_idx[r_rptr];
    assign w_head_taken = r_q_taken[r_rptr];
    assign w_head_cur   = r_table[w_head_idx];
    assign w_pred_idx   = i_pred_pc[INDEX_BITS+1:2];

    always_comb begin
        w_head_new = w_head_cur;
        if (w_head_taken) begin
            if (w_head_cur != 2'd3) w_head_new = w_head_cur + 2'd1;
        end else begin
            if (w_head_cur != 2'd0) w_head_new = w_head_cur - 2'd1;
        end
    end

    // Write-first: a lookup colliding with this cycle's drain sees the new value.
    always_comb begin
        w_pred_cnt = r_table[w_pred_idx];
        if (w_deq && (w_head_idx == w_pred_idx)) w_pred_cnt = w_head_new;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) r_table[i] <= 2'd1;
        end else if (w_deq) begin
            r_table[w_head_idx] <= w_head_new;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_idx[r_wptr]   <= i_upd_pc[INDEX_BITS+1:2];
            r_q_taken[r_wptr] <= i_upd_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid   <= 1'b0;
            r_pred_taken   <= 1'b0;
            r_pred_counter <= 2'd0;
        end else begin
            r_pred_valid <= i_pred_valid;
            if (i_pred_valid) begin
                r_pred_taken   <= w_pred_cnt[1];
                r_pred_counter <= w_pred_cnt;
            end
        end
    end

    assign o_pred_valid   = r_pred_valid;
    assign o_pred_taken   = r_pred_taken;
    assign o_pred_counter = r_pred_counter;
    assign o_updq_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_bp_bht.sv
// Scoreboarded bench for fetch_bp_bht: directed scenarios plus a random soak.
`default_nettype none

module tb_fetch_bp_bht;

    localparam int IB    = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_pred_valid = 1'b0;
    logic [31:0] i_pred_pc = '0;
    logic        o_pred_valid;
    logic        o_pred_taken;
    logic [1:0]  o_pred_counter;
    logic        i_upd_valid = 1'b0;
    logic        o_upd_ready;
    logic [31:0] i_upd_pc = '0;
    logic        i_upd_taken = 1'b0;
    logic [$clog2(DEPTH):0] o_updq_count;

    fetch_bp_bht #(.INDEX_BITS(IB), .UPDQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pred_valid   (i_pred_valid),
        .i_pred_pc      (i_pred_pc),
        .o_pred_valid   (o_pred_valid),
        .o_pred_taken   (o_pred_taken),
        .o_pred_counter (o_pred_counter),
        .i_upd_valid    (i_upd_valid),
        .o_upd_ready    (o_upd_ready),
        .i_upd_pc       (i_upd_pc),
        .i_upd_taken    (i_upd_taken),
        .o_updq_count   (o_updq_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];          // expected counter per lookup, in issue order
    int m_q[$];         // reference queue: {index, taken}
    int m_tbl[1 << IB]; // reference counters

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int c, input int t);
        if (t != 0) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & ((1 << IB) - 1));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << IB); i++) m_tbl[i] = 1;
        m_q.delete();
        sb.delete();
    endtask

    // One clock of stimulus. hand >= 0 supplies a hand-computed expectation.
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic uv,
                       input logic [31:0] upc, input logic ut, input int hand);
        int h_idx, h_t, newv, exp;
        bit drain, rdy;
        @(negedge clk);
        chk("updq_count", int'(o_updq_count), m_q.size());
        chk("upd_ready", int'(o_upd_ready), (m_q.size() != DEPTH) ? 1 : 0);
        i_pred_valid = pv; i_pred_pc = ppc;
        i_upd_valid = uv; i_upd_pc = upc; i_upd_taken = ut;
        drain = (m_q.size() != 0);
        h_idx = 0; h_t = 0; newv = 0;
        if (drain) begin
            h_idx = m_q[0] >> 1;
            h_t   = m_q[0] & 1;
            newv  = sat(m_tbl[h_idx], h_t);
        end
        if (pv) begin
            if (hand >= 0) exp = hand;
            else if (drain && h_idx == idx_of(ppc)) exp = newv;
            else exp = m_tbl[idx_of(ppc)];
            sb.push_back(exp);
        end
        rdy = (m_q.size() != DEPTH);
        if (drain) begin
            m_tbl[h_idx] = newv;
            void'(m_q.pop_front());
        end
        if (uv && rdy) m_q.push_back((idx_of(upc) << 1) | int'(ut));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    endtask

    task automatic look(input logic [31:0] pc, input int hand);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, hand);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_pred_valid = 1'b0; i_upd_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_pred_valid", int'(o_pred_valid), 0);
        chk("rst_pred_taken", int'(o_pred_taken), 0);
        chk("rst_pred_counter", int'(o_pred_counter), 0);
        chk("rst_count", int'(o_updq_count), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops one expectation per presented prediction.
    always @(negedge clk) begin
        int e;
        if (!reset && o_pred_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pred: got counter %0d with no pending lookup", o_pred_counter);
            end else begin
                e = sb.pop_front();
                chk("pred_counter", int'(o_pred_counter), e);
                chk("pred_taken", int'(o_pred_taken), (e >> 1) & 1);
            end
        end
    end

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("init_pred_valid", int'(o_pred_valid), 0);
        chk("init_count", int'(o_updq_count), 0);
        chk("init_ready", int'(o_upd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Saturation ramp up on 0x40 with overlapping lookups
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 2);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 3);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 3);
        look(32'h40, 3);
        idle(4);
        look(32'h40, 3);
        // Ramp down
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 3);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 2);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 0);
        cyc(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 0);
        look(32'h40, 0);
        idle(4);
        look(32'h40, 0);

        // Mid-stream reset with an outcome still queued
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, -1);
        do_reset();
        look(32'h100, 1);
        look(32'h40, 1);

        // Write-first bypass
        cyc(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1);
        look(32'h80, 2);
        cyc(1'b1, 32'h88, 1'b1, 32'h88, 1'b1, 1);
        look(32'h8C, 1);
        look(32'h88, 2);

        // Aliasing: 0x000 and 0x100 share index 0
        cyc(1'b0, 32'h0, 1'b1, 32'h000, 1'b1, -1);
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, -1);
        idle(2);
        look(32'h000, 1);
        look(32'h100, 1);

        // Back-to-back burst into one index
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 32'hC0, 1'b1, -1);
        idle(2);
        look(32'hC0, 3);

        // Random soak with dense aliasing and pointer wrap
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), {23'($urandom), 7'($urandom_range(0, 127)), 2'b00},
                1'($urandom_range(0, 3) != 0), {23'($urandom), 3'b000, 4'($urandom_range(0, 15)), 2'b00},
                1'($urandom_range(0, 1)), -1);
        end
        idle(4);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL pending_lookups: got %0d outstanding expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
